bfm: RTL and testbench

// - Registered two-operand adder. It is the datapath behind the DPI stimulus wrapper.
// - Each clock it samples operands A_s and B_s and returns their sum on res_o after a

---
 rtl/bfm.sv | 87 ++++++++
 tb/tb_bfm.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bfm.sv
`default_nettype none
// ============================================================================
// Module   : bfm
// Purpose  : Registered two-operand unsigned adder with a fixed, parameterised
//            pipeline latency. It accepts one operand pair on every clock, has
//            no handshake, and drives its output only from registers.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH    operand and result width (default 8)
//   LATENCY  rising edges from operand sampling to res_o update, 1..8
//            (default 1)
// Ports
//   clk_i    in   1      clock; all state updates on the rising edge
//   reset_i  in   1      asynchronous reset, active-low (0 = in reset)
//   A_s      in   WIDTH  operand A, sampled every rising edge
//   B_s      in   WIDTH  operand B, sampled every rising edge
//   res_o    out  WIDTH  registered sum
// Configuration
//   BFM_SAT_EN  When this macro is defined, the stage-1 adder saturates to
//               all-ones when the sum does not fit in WIDTH bits. When it is
//               undefined, the adder wraps modulo 2^WIDTH. Ports and timing
//               are the same in both builds.
// ============================================================================
module bfm #(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] A_s,
  input  logic [WIDTH-1:0] B_s,
  output logic [WIDTH-1:0] res_o
);

  // Stage-1 adder
  logic [WIDTH-1:0] w_sum;

`ifdef BFM_SAT_EN
  // Widen by one bit so that the carry-out can select the clamp value.
  logic [WIDTH:0] w_sum_full;
  assign w_sum_full = {1'b0, A_s} + {1'b0, B_s};
  assign w_sum      = w_sum_full[WIDTH] ? {WIDTH{1'b1}} : w_sum_full[WIDTH-1:0];
`else
  // The carry-out is discarded, so the result wraps modulo 2^WIDTH.
  assign w_sum = A_s + B_s;
`endif

  // Stage 1 always exists. It is the output register when LATENCY is 1.
  logic [WIDTH-1:0] r_stage1;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_stage1 <= '0;
    end else begin
      r_stage1 <= w_sum;
    end
  end

  generate
    if (LATENCY <= 1) begin : g_lat1
      assign res_o = r_stage1;
    end else begin : g_latn
      // Delay line of LATENCY-1 stages after the adder. Reset clears every
      // stage, so any result still in flight is discarded and the pipeline
      // refills from zero after release.
      logic [WIDTH-1:0] r_dly [LATENCY-1];

      always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
          for (int k = 0; k < LATENCY - 1; k++) begin
            r_dly[k] <= '0;
          end
        end else begin
          r_dly[0] <= r_stage1;
          for (int k = 1; k < LATENCY - 1; k++) begin
            r_dly[k] <= r_dly[k-1];
          end
        end
      end

      assign res_o = r_dly[LATENCY-2];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_bfm.sv
`default_nettype none
// ============================================================================
// Module   : tb_bfm
// Purpose  : Directed self-checking bench for bfm. It drives one LATENCY=1
//            instance and one LATENCY=3 instance from the same stimulus.
// Revision : 1.0  initial release
// ============================================================================
module tb_bfm;

  logic       clk_i;
  logic       reset_i;
  logic [7:0] A_s;
  logic [7:0] B_s;
  logic [7:0] res1;
  logic [7:0] res3;

  int checks;
  int failures;

  bfm #(.WIDTH(8), .LATENCY(1)) u_dut1 (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .A_s    (A_s),
    .B_s    (B_s),
    .res_o  (res1)
  );

  bfm #(.WIDTH(8), .LATENCY(3)) u_dut3 (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .A_s    (A_s),
    .B_s    (B_s),
    .res_o  (res3)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Reference sum for the build in use.
  function automatic logic [7:0] f_add(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
`ifdef BFM_SAT_EN
    if (s > 9'd255) return 8'hFF;
`endif
    return s[7:0];
  endfunction

  // Wait for a rising edge, then let the outputs settle.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    reset_i = 1'b0;
    A_s     = 8'hFF;
    B_s     = 8'h01;
    #1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (res1 !== 8'd0) begin
        failures++;
        $display("FAIL reset_hold_lat1 cycle %0d: got %0d expected 0", i, res1);
      end
      checks++;
      if (res3 !== 8'd0) begin
        failures++;
        $display("FAIL reset_hold_lat3 cycle %0d: got %0d expected 0", i, res3);
      end
    end
  endtask

  task automatic test_basic_add();
    reset_i = 1'b1;
    A_s     = 8'd3;
    B_s     = 8'd4;
    step();
    checks++;
    if (res1 !== 8'd7) begin
      failures++;
      $display("FAIL basic_add: got %0d expected 7", res1);
    end
    // The LATENCY=3 instance has not refilled yet.
    checks++;
    if (res3 !== 8'd0) begin
      failures++;
      $display("FAIL basic_refill_lat3: got %0d expected 0", res3);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_v;
`ifdef BFM_SAT_EN
    exp_v = 8'd255;
`else
    exp_v = 8'd44;
`endif
    A_s = 8'd200;
    B_s = 8'd100;
    step();
    checks++;
    if (res1 !== exp_v) begin
      failures++;
      $display("FAIL wrap_200_100: got %0d expected %0d", res1, exp_v);
    end
    A_s = 8'd255;
    B_s = 8'd0;
    step();
    checks++;
    if (res1 !== 8'd255) begin
      failures++;
      $display("FAIL add_255_0: got %0d expected 255", res1);
    end
    A_s = 8'd128;
    B_s = 8'd128;
    step();
    checks++;
`ifdef BFM_SAT_EN
    exp_v = 8'd255;
`else
    exp_v = 8'd0;
`endif
    if (res1 !== exp_v) begin
      failures++;
      $display("FAIL wrap_128_128: got %0d expected %0d", res1, exp_v);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp1;
    logic [7:0] exp3;
    for (int i = 0; i < 100; i++) begin
      A_s = 8'(i);
      B_s = 8'(2 * i);
      step();
      exp1 = f_add(8'(i), 8'(2 * i));
      checks++;
      if (res1 !== exp1) begin
        failures++;
        $display("FAIL stream_lat1 i=%0d: got %0d expected %0d", i, res1, exp1);
      end
      if (i >= 2) begin
        exp3 = f_add(8'(i - 2), 8'(2 * (i - 2)));
        checks++;
        if (res3 !== exp3) begin
          failures++;
          $display("FAIL stream_lat3 i=%0d: got %0d expected %0d", i, res3, exp3);
        end
      end
    end
  endtask

  task automatic test_latency();
    logic [7:0] exp3;
    A_s = 8'd0;
    B_s = 8'd0;
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (res3 !== 8'd0) begin
      failures++;
      $display("FAIL latency_flushed: got %0d expected 0", res3);
    end
    A_s = 8'd10;
    B_s = 8'd20;
    step();                       // edge N samples the pair
    A_s = 8'd0;
    B_s = 8'd0;
    for (int k = 0; k < 5; k++) begin
      exp3 = (k == 2) ? 8'd30 : 8'd0;
      checks++;
      if (res3 !== exp3) begin
        failures++;
        $display("FAIL latency_lat3 edge N+%0d: got %0d expected %0d", k, res3, exp3);
      end
      step();
    end
  endtask

  task automatic test_reset_midstream();
    logic [7:0] exp3;
    A_s = 8'd5;
    B_s = 8'd6;
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (res3 !== 8'd11) begin
      failures++;
      $display("FAIL midstream_prefill: got %0d expected 11", res3);
    end
    // Assert reset between edges. Both outputs must clear before the next edge.
    #2;
    reset_i = 1'b0;
    A_s     = 8'hxx;
    B_s     = 8'hxx;
    #1;
    checks++;
    if (res3 !== 8'd0) begin
      failures++;
      $display("FAIL async_reset_lat3: got %0d expected 0", res3);
    end
    checks++;
    if (res1 !== 8'd0) begin
      failures++;
      $display("FAIL async_reset_lat1: got %0d expected 0", res1);
    end
    step();
    checks++;
    if (res1 !== 8'd0) begin
      failures++;
      $display("FAIL reset_x_operand: got %0d expected 0", res1);
    end
    reset_i = 1'b1;
    A_s     = 8'd1;
    B_s     = 8'd2;
    for (int k = 0; k < 4; k++) begin
      step();
      exp3 = (k < 2) ? 8'd0 : 8'd3;
      checks++;
      if (res3 !== exp3) begin
        failures++;
        $display("FAIL post_reset_lat3 edge N+%0d: got %0d expected %0d", k, res3, exp3);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset_i  = 1'b0;
    A_s      = 8'd0;
    B_s      = 8'd0;
    test_reset();
    test_basic_add();
    test_wrap();
    test_back_to_back();
    test_latency();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
